// File: rtl/cmp_counter_bank.sv
// Multi-channel compare-and-count bank: each channel counts when its a/b compare
// holds under the shared mode, with terminal count (wrap or saturate), tc pulse and sticky ovf.
module cmp_counter_bank #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 6,
    parameter int CNT_W     = 5,
    parameter int MAX_COUNT = (1 << CNT_W) - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       en_in,
    input  logic [1:0]                 mode_in,
    input  logic [NUM_CH*DATA_W-1:0]   a_in,
    input  logic [NUM_CH*DATA_W-1:0]   b_in,
    input  logic [NUM_CH-1:0]          clear_in,
    input  logic [NUM_CH-1:0]          load_in,
    input  logic [CNT_W-1:0]           load_val_in,
    output logic [NUM_CH*CNT_W-1:0]    c_out,
    output logic [NUM_CH-1:0]          tc_out,
    output logic [NUM_CH-1:0]          ovf_out
);

    localparam logic [1:0] MODE_LE   = 2'b00;
    localparam logic [1:0] MODE_GT   = 2'b01;
    localparam logic [1:0] MODE_EQ   = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    if (MAX_COUNT < 1 || MAX_COUNT > (1 << CNT_W) - 1) begin : g_bad_max_count
        $error("cmp_counter_bank: MAX_COUNT %0d outside 1..%0d", MAX_COUNT, (1 << CNT_W) - 1);
    end

    // Load value clamped to the terminal count; no clamp needed when MAX_COUNT is full range.
    logic [CNT_W-1:0] load_clamped;
    if (MAX_COUNT == (1 << CNT_W) - 1) begin : g_no_clamp
        assign load_clamped = load_val_in;
    end else begin : g_clamp
        assign load_clamped = (load_val_in > MAX_C) ? MAX_C : load_val_in;
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [DATA_W-1:0] a_val;
        logic [DATA_W-1:0] b_val;
        logic              hit;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              tc_q, tc_d;
        logic              ovf_q, ovf_d;

        assign a_val = a_in[ch*DATA_W +: DATA_W];
        assign b_val = b_in[ch*DATA_W +: DATA_W];

        always_comb begin
            hit = 1'b0;
            case (mode_in)
                MODE_LE:   hit = (a_val <= b_val);
                MODE_GT:   hit = (a_val >  b_val);
                MODE_EQ:   hit = (a_val == b_val);
                MODE_HOLD: hit = 1'b0;
                default:   hit = 1'b0;
            endcase
        end

        always_comb begin
            cnt_d = cnt_q;
            tc_d  = 1'b0;
            ovf_d = ovf_q;
            if (clear_in[ch]) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (load_in[ch]) begin
                cnt_d = load_clamped;
            end else if (en_in && hit) begin
                if (cnt_q == MAX_C) begin
                    cnt_d = SATURATE ? MAX_C : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tc_q  <= tc_d;
                ovf_q <= ovf_d;
            end
        end

        assign c_out[ch*CNT_W +: CNT_W] = cnt_q;
        assign tc_out[ch]               = tc_q;
        assign ovf_out[ch]              = ovf_q;
    end

endmodule

// File: tb/tb_cmp_counter_bank.sv
// Bench for cmp_counter_bank: a wrapping instance (defaults) and a saturating instance
// (MAX_COUNT=10) share stimulus; a per-channel arithmetic model predicts every cycle.
module tb_cmp_counter_bank;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 6;
  localparam int CNT_W  = 5;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic [1:0]               mode;
  logic [NUM_CH*DATA_W-1:0] a_v, b_v;
  logic [NUM_CH-1:0]        clr, ld;
  logic [CNT_W-1:0]         ld_val;
  logic [NUM_CH*CNT_W-1:0]  c_w, c_s;
  logic [NUM_CH-1:0]        tc_w, tc_s, ovf_w, ovf_s;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: index 0 = wrapping instance, 1 = saturating instance
  int m_c[2][NUM_CH];
  bit m_tc[2][NUM_CH];
  bit m_ovf[2][NUM_CH];
  int m_max[2] = '{31, 10};
  bit m_sat[2] = '{1'b0, 1'b1};

  logic [31:0] exp_q[$];

  cmp_counter_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut_wrap (
    .clk_in(clk), .rst_in(rst), .en_in(en), .mode_in(mode),
    .a_in(a_v), .b_in(b_v), .clear_in(clr), .load_in(ld), .load_val_in(ld_val),
    .c_out(c_w), .tc_out(tc_w), .ovf_out(ovf_w)
  );

  cmp_counter_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
                     .MAX_COUNT(10), .SATURATE(1'b1)) dut_sat (
    .clk_in(clk), .rst_in(rst), .en_in(en), .mode_in(mode),
    .a_in(a_v), .b_in(b_v), .clear_in(clr), .load_in(ld), .load_val_in(ld_val),
    .c_out(c_s), .tc_out(tc_s), .ovf_out(ovf_s)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_c[d][ch] = 0; m_tc[d][ch] = 0; m_ovf[d][ch] = 0;
      end
  endtask

  // one clock edge of the behavioural rules for every channel of both instances
  task automatic model_step();
    int a, b;
    bit cond;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NUM_CH; ch++) begin
        a = int'(a_v[ch*DATA_W +: DATA_W]);
        b = int'(b_v[ch*DATA_W +: DATA_W]);
        case (mode)
          2'd0:    cond = (a <= b);
          2'd1:    cond = (a > b);
          2'd2:    cond = (a == b);
          default: cond = 1'b0;
        endcase
        m_tc[d][ch] = 1'b0;
        if (clr[ch]) begin
          m_c[d][ch] = 0; m_ovf[d][ch] = 1'b0;
        end else if (ld[ch]) begin
          m_c[d][ch] = (int'(ld_val) > m_max[d]) ? m_max[d] : int'(ld_val);
        end else if (en && cond) begin
          if (m_c[d][ch] == m_max[d]) begin
            m_tc[d][ch] = 1'b1; m_ovf[d][ch] = 1'b1;
            m_c[d][ch] = m_sat[d] ? m_max[d] : 0;
          end else begin
            m_c[d][ch] = m_c[d][ch] + 1;
          end
        end
      end
  endtask

  // scoreboard: expected packed words go through exp_q, then compared against both instances
  task automatic check_all(input string tag);
    logic [31:0] e_c, e_tc, e_ovf, obs_c, obs_tc, obs_ovf;
    for (int d = 0; d < 2; d++) begin
      e_c = '0; e_tc = '0; e_ovf = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        e_c[ch*CNT_W +: CNT_W] = CNT_W'(m_c[d][ch]);
        e_tc[ch]  = m_tc[d][ch];
        e_ovf[ch] = m_ovf[d][ch];
      end
      exp_q.push_back(e_c); exp_q.push_back(e_tc); exp_q.push_back(e_ovf);
    end
    for (int d = 0; d < 2; d++) begin
      obs_c   = (d == 0) ? 32'(c_w)   : 32'(c_s);
      obs_tc  = (d == 0) ? 32'(tc_w)  : 32'(tc_s);
      obs_ovf = (d == 0) ? 32'(ovf_w) : 32'(ovf_s);
      chk($sformatf("%s_%s_c",   tag, d == 0 ? "wrap" : "sat"), obs_c,   exp_q.pop_front());
      chk($sformatf("%s_%s_tc",  tag, d == 0 ? "wrap" : "sat"), obs_tc,  exp_q.pop_front());
      chk($sformatf("%s_%s_ovf", tag, d == 0 ? "wrap" : "sat"), obs_ovf, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_ch(input int ch, input int a, input int b);
    a_v[ch*DATA_W +: DATA_W] = DATA_W'(a);
    b_v[ch*DATA_W +: DATA_W] = DATA_W'(b);
  endtask

  task automatic set_all(input int a, input int b);
    for (int ch = 0; ch < NUM_CH; ch++) set_ch(ch, a, b);
  endtask

  task automatic clear_all();
    clr = '1; ld = '0;
    tick("clear");
    clr = '0;
  endtask

  function automatic logic [31:0] cw(input int ch);
    return 32'(c_w[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [31:0] cs(input int ch);
    return 32'(c_s[ch*CNT_W +: CNT_W]);
  endfunction

  initial begin
    int snap[NUM_CH];
    rst = 1'b1; en = 1'b0; mode = 2'b00; a_v = '0; b_v = '0;
    clr = '0; ld = '0; ld_val = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset_init");
    #3 rst = 1'b0;

    // wrap at terminal count on the default instance
    mode = 2'b00; en = 1'b1; set_all(0, 0); set_ch(0, 3, 5);
    repeat (31) tick("t2_run");
    chk("t2_c31", cw(0), 32'd31);
    chk("t2_tc_pre", 32'(tc_w[0]), 32'd0);
    tick("t2_wrap");
    chk("t2_c0", cw(0), 32'd0);
    chk("t2_tc", 32'(tc_w[0]), 32'd1);
    chk("t2_ovf", 32'(ovf_w[0]), 32'd1);
    en = 1'b0;
    tick("t2_after");
    chk("t2_tc_drop", 32'(tc_w[0]), 32'd0);
    chk("t2_ovf_sticky", 32'(ovf_w[0]), 32'd1);

    // saturation at MAX_COUNT=10
    clear_all();
    mode = 2'b01; en = 1'b1; set_all(9, 2);
    for (int i = 1; i <= 15; i++) begin
      tick("t3_run");
      chk($sformatf("t3_c_%0d", i), cs(0), 32'(i > 10 ? 10 : i));
      chk($sformatf("t3_tc_%0d", i), 32'(tc_s[0]), 32'(i >= 11));
    end
    chk("t3_ovf", 32'(ovf_s[0]), 32'd1);

    // equality mode, per-channel conditions
    clear_all();
    mode = 2'b10; en = 1'b1; set_ch(0, 5, 5); set_ch(1, 5, 6); set_ch(3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      set_ch(2, 7, (i % 2 == 0) ? 7 : 8);
      tick("t4_run");
    end
    chk("t4_ch0", cw(0), 32'd8);
    chk("t4_ch1", cw(1), 32'd0);
    chk("t4_ch2", cw(2), 32'd4);

    // en_in toggling every cycle
    clear_all();
    set_all(12, 12);
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      tick("t4_en");
    end
    chk("t4_en_ch0", cw(0), 32'd4);

    // load clamp, overflow, then clear-over-load on the same edge
    en = 1'b1; ld_val = 5'd31; ld = 4'b0011;
    tick("t5_load31");
    chk("t5_sat_clamp", cs(0), 32'd10);
    ld = '0;
    tick("t5_ovf");
    chk("t5_ovf_set", 32'(ovf_w[1:0]), 32'd3);
    clr = 4'b0001; ld = 4'b0011; ld_val = 5'd7; en = 1'b0;
    tick("t5_clr_ld");
    chk("t5_ch0", cw(0), 32'd0);
    chk("t5_ch0_ovf", 32'(ovf_w[0]), 32'd0);
    chk("t5_ch1", cw(1), 32'd7);
    chk("t5_ch1_ovf", 32'(ovf_w[1]), 32'd1);
    clr = '0; ld = '0;

    // hold mode
    for (int ch = 0; ch < NUM_CH; ch++) snap[ch] = int'(cw(ch));
    mode = 2'b11; en = 1'b1; set_all(4, 4);
    repeat (10) tick("t6_hold");
    for (int ch = 0; ch < NUM_CH; ch++) chk($sformatf("t6_c%0d", ch), cw(ch), 32'(snap[ch]));
    chk("t6_tc", 32'(tc_w), 32'd0);

    // asynchronous reset between edges with counters nonzero
    mode = 2'b00; set_all(1, 2);
    repeat (3) tick("t1_prep");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t1_async");
    @(posedge clk);
    #1;
    check_all("t1_hold");
    #2 rst = 1'b0;
    tick("t1_first");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode   = 2'($urandom_range(0, 3));
      en     = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < NUM_CH; ch++)
        set_ch(ch, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        clr[ch] = ($urandom_range(0, 31) == 0);
        ld[ch]  = ($urandom_range(0, 15) == 0);
      end
      ld_val = CNT_W'($urandom_range(0, 31));
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
